// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the 6502 core, the DMA/debug port and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_bus_arbiter_if #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rdy;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter state, visible for debug and checkers.
    logic          dbg_own;
    logic [WW-1:0] dbg_wait_cnt;
    logic [BW-1:0] dbg_burst_cnt;

    // Handshake: a requester holds req and its address/data stable until the
    // arbiter accepts it in the same cycle (cpu_rdy / dma_gnt high). Read data
    // appears one cycle after acceptance; writes complete in the accepted cycle.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdy, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output dbg_own, dbg_wait_cnt, dbg_burst_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdy, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  dbg_own, dbg_wait_cnt, dbg_burst_cnt
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-way memory bus arbiter: core has priority, DMA gets a bounded wait
// before grant and a bounded burst once it owns the bus.
module mem_bus_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              ph1,
    input  logic              resetb,
    mem_bus_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] WAIT_TOP  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_TOP = BW'(BURST_MAX);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } own_t;

    own_t          r_own;
    own_t          w_own_nxt;
    logic [WW-1:0] r_wait_cnt;
    logic [WW-1:0] w_wait_nxt;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_nxt;
    logic          r_rd_pend_dma;
    logic          w_rd_pend_nxt;
    logic          w_g_dma;
    logic          w_wait_full;
    logic          w_burst_left;

    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            r_own         <= CPU_OWN;
            r_wait_cnt    <= '0;
            r_burst_cnt   <= '0;
            r_rd_pend_dma <= 1'b0;
        end else begin
            r_own         <= w_own_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_rd_pend_dma <= w_rd_pend_nxt;
        end
    end

    // Grant is decided in the same cycle; ownership just remembers it.
    always_comb begin
        w_wait_full  = (r_wait_cnt == WAIT_TOP);
        w_burst_left = (r_burst_cnt < BURST_TOP);
        w_g_dma      = 1'b0;
        if (r_own == CPU_OWN) begin
            w_g_dma = bus.dma_req & (~bus.cpu_req | w_wait_full);
        end else begin
            w_g_dma = bus.dma_req & (~bus.cpu_req | w_burst_left);
        end

        w_own_nxt = w_g_dma ? DMA_OWN : CPU_OWN;

        w_wait_nxt = '0;
        if (bus.dma_req && !w_g_dma) begin
            w_wait_nxt = w_wait_full ? r_wait_cnt : r_wait_cnt + 1'b1;
        end

        // An exhausted burst with an idle core keeps the bus at BURST_TOP.
        w_burst_nxt = '0;
        if (w_g_dma) begin
            w_burst_nxt = w_burst_left ? r_burst_cnt + 1'b1 : r_burst_cnt;
        end

        w_rd_pend_nxt = w_g_dma & ~bus.dma_we;
    end

    always_comb begin
        bus.dma_gnt    = w_g_dma;
        bus.cpu_rdy    = ~w_g_dma;
        bus.dma_rvalid = r_rd_pend_dma;
        bus.dma_rdata  = bus.mem_rdata;
        bus.cpu_rdata  = bus.mem_rdata;

        if (w_g_dma) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else begin
            bus.mem_en    = bus.cpu_req;
            bus.mem_we    = bus.cpu_we & bus.cpu_req;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end

        bus.dbg_own       = r_own;
        bus.dbg_wait_cnt  = r_wait_cnt;
        bus.dbg_burst_cnt = r_burst_cnt;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed cycles push expected control
// and read data; a negedge monitor pops and compares.
module tb_mem_bus_arbiter;
    logic ph1;
    logic resetb;

    mem_bus_arbiter_if #(.AW(16), .DW(8), .MAX_WAIT(4), .BURST_MAX(8)) bus ();

    mem_bus_arbiter #(.AW(16), .DW(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .ph1    (ph1),
        .resetb (resetb),
        .bus    (bus)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    logic [7:0] mem [0:65535];
    logic [7:0] mem_rd;

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        if (a == 16'hFFFC) return 8'h00;
        if (a == 16'hFFFD) return 8'hF0;
        return mem[a];
    endfunction

    always @(posedge ph1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rd <= mem_read(bus.mem_addr);
        end
    end
    assign bus.mem_rdata = mem_rd;

    int n_tests;
    int n_fail;
    logic [19:0] ctl_q[$];
    logic [7:0]  cpu_rd_q[$];
    logic [7:0]  dma_rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        logic       cpu_pend;
        logic [7:0] e;
        cpu_pend = 1'b0;
        forever begin
            @(negedge ph1);
            if (ctl_q.size() > 0) begin
                chk("ctl{gnt,rdy,en,we,addr}",
                    {12'h0, bus.dma_gnt, bus.cpu_rdy, bus.mem_en, bus.mem_we, bus.mem_addr},
                    {12'h0, ctl_q.pop_front()});
            end
            if (bus.dma_rvalid) begin
                if (dma_rd_q.size() == 0) chk("dma_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e = dma_rd_q.pop_front();
                    chk("dma_rdata", {24'h0, bus.dma_rdata}, {24'h0, e});
                end
            end
            if (cpu_pend) begin
                if (cpu_rd_q.size() == 0) chk("cpu_read_unexpected", 32'd1, 32'd0);
                else begin
                    e = cpu_rd_q.pop_front();
                    chk("cpu_rdata", {24'h0, bus.cpu_rdata}, {24'h0, e});
                end
            end
            cpu_pend = bus.cpu_req & bus.cpu_rdy & ~bus.cpu_we;
        end
    endtask

    task automatic drive_cycle(input logic creq, input logic cwe, input logic [15:0] caddr,
                               input logic [7:0] cwd, input logic dreq, input logic dwe,
                               input logic [15:0] daddr, input logic [7:0] dwd,
                               input logic egnt);
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dma_req   = dreq;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwd;
        ctl_q.push_back({egnt, ~egnt, egnt | creq, egnt ? dwe : (cwe & creq),
                         egnt ? daddr : caddr});
        @(posedge ph1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_cycle(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    endtask

    initial begin
        logic [13:0] cont_pat;
        n_tests = 0;
        n_fail  = 0;
        resetb  = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        fork
            monitor_loop();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        #2;
        chk("reset_own",   {31'h0, bus.dbg_own}, 32'd0);
        chk("reset_wait",  {29'h0, bus.dbg_wait_cnt}, 32'd0);
        chk("reset_burst", {28'h0, bus.dbg_burst_cnt}, 32'd0);
        chk("reset_rvalid", {31'h0, bus.dma_rvalid}, 32'd0);
        chk("reset_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'd1);
        chk("reset_dma_gnt", {31'h0, bus.dma_gnt}, 32'd0);
        #10 resetb = 1'b1;
        @(posedge ph1);
        #1;

        // Core only: write 0x42 to 0x0040, read it back.
        drive_cycle(1, 1, 16'h0040, 8'h42, 0, 0, 16'h0000, 8'h00, 0);
        drive_cycle(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
        cpu_rd_q.push_back(8'h42);
        idle(2);

        // DMA only: reset vector reads.
        drive_cycle(0, 0, 16'h0000, 8'h00, 1, 0, 16'hFFFC, 8'h00, 1);
        dma_rd_q.push_back(8'h00);
        drive_cycle(0, 0, 16'h0000, 8'h00, 1, 0, 16'hFFFD, 8'h00, 1);
        dma_rd_q.push_back(8'hF0);
        idle(2);

        // Contention: core wins 0-3, DMA forced 4-11, core back on 12-13.
        cont_pat = 14'b00_1111_1111_0000;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1, 0, 16'h0040, 8'h00, 1, 1, 16'h0100 + 16'(i), 8'(i), cont_pat[i]);
            if (!cont_pat[i]) cpu_rd_q.push_back(8'h42);
        end
        chk("contention_own_after", {31'h0, bus.dbg_own}, 32'd0);
        chk("contention_wait_recount", {29'h0, bus.dbg_wait_cnt}, 32'd2);
        idle(2);

        // DMA burst with idle core; core raises request only on cycle 15.
        for (int i = 0; i < 20; i++) begin
            if (i == 15) begin
                drive_cycle(1, 0, 16'h0040, 8'h00, 1, 1, 16'h0200 + 16'(i), 8'(i), 0);
                cpu_rd_q.push_back(8'h42);
            end else begin
                drive_cycle(0, 0, 16'h0000, 8'h00, 1, 1, 16'h0200 + 16'(i), 8'(i), 1);
            end
            if (i == 11 || i == 14) chk("burst_saturate", {28'h0, bus.dbg_burst_cnt}, 32'd8);
            if (i == 15) chk("burst_clear_on_core", {28'h0, bus.dbg_burst_cnt}, 32'd0);
        end
        idle(2);

        // Reset with a DMA read in flight: the read must be discarded.
        drive_cycle(0, 0, 16'h0000, 8'h00, 1, 0, 16'hFFFD, 8'h00, 1);
        #2;
        resetb = 1'b0;
        bus.dma_req = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("midreset_rvalid", {31'h0, bus.dma_rvalid}, 32'd0);
        chk("midreset_own",    {31'h0, bus.dbg_own}, 32'd0);
        chk("midreset_burst",  {28'h0, bus.dbg_burst_cnt}, 32'd0);
        chk("midreset_wait",   {29'h0, bus.dbg_wait_cnt}, 32'd0);
        #99;
        resetb = 1'b1;
        drive_cycle(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
        cpu_rd_q.push_back(8'h42);
        idle(2);

        chk("ctl_q_drained",    ctl_q.size(), 32'd0);
        chk("cpu_rd_q_drained", cpu_rd_q.size(), 32'd0);
        chk("dma_rd_q_drained", dma_rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
